// File: rtl/pd_4b5b_tx_framer.sv
// USB-PD transmit framer: ordered set, 4b5b payload, EOP.
// Registered symbol output with valid/ready flow control.
module pd_4b5b_tx_framer #(
  parameter int IN_BYTES  = 1,
  parameter int MAX_BYTES = 264
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            sop_type,
  input  logic [8*IN_BYTES-1:0] s_data,
  input  logic [IN_BYTES-1:0]   s_keep,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [4:0]            m_sym,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, OSET, DATA, DRAIN, EOP, DONE
  } state_t;

  localparam logic [16:0] MAXV = 17'(MAX_BYTES);
  localparam logic [4:0] K_S1  = 5'b11000;
  localparam logic [4:0] K_S2  = 5'b10001;
  localparam logic [4:0] K_S3  = 5'b00110;
  localparam logic [4:0] K_R1  = 5'b00111;
  localparam logic [4:0] K_R2  = 5'b11001;
  localparam logic [4:0] K_EOP = 5'b01101;

  state_t                state_q, state_d;
  logic [2:0]            type_q, type_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [8*IN_BYTES-1:0] bdata_q, bdata_d;
  logic [2:0]            bn_q, bn_d;
  logic [2:0]            blane_q, blane_d;
  logic                  bhi_q, bhi_d;
  logic                  bvld_q, bvld_d;
  logic                  blast_q, blast_d;
  logic                  bdrain_q, bdrain_d;
  logic [4:0]            sym_q, sym_d;
  logic                  mvld_q, mvld_d;
  logic                  mlast_q, mlast_d;
  logic                  err_q, err_d;

  logic        load;
  logic        acc;
  logic [2:0]  n_in;
  logic [2:0]  take;
  logic [16:0] sum;
  logic        ovf;
  logic [7:0]  cur_byte;
  logic [3:0]  cur_nib;

  function automatic logic [4:0] enc(
    input logic [3:0] n
  );
    logic [4:0] s;
    unique case (n)
      4'h0: s = 5'b11110;
      4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;
      4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;
      4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;
      4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;
      4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;
      4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;
      4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;
      default: s = 5'b11101;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] oset(
    input logic [2:0] t,
    input logic [1:0] i
  );
    logic [19:0] seq;
    logic [4:0]  s;
    unique case (t)
      3'd0:    seq = {K_S1, K_S1, K_S1, K_S2};
      3'd1:    seq = {K_S1, K_S1, K_S3, K_S3};
      3'd2:    seq = {K_S1, K_S3, K_S1, K_S3};
      3'd3:    seq = {K_S1, K_R2, K_R2, K_S3};
      3'd4:    seq = {K_S1, K_R2, K_S3, K_S2};
      3'd5:    seq = {K_R1, K_R1, K_R1, K_R2};
      default: seq = {K_R1, K_S1, K_R1, K_S3};
    endcase
    unique case (i)
      2'd0:    s = seq[19:15];
      2'd1:    s = seq[14:10];
      2'd2:    s = seq[9:5];
      default: s = seq[4:0];
    endcase
    return s;
  endfunction

  function automatic logic [2:0] pop(
    input logic [IN_BYTES-1:0] k
  );
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < IN_BYTES; i++) begin
      c = c + 3'(k[i]);
    end
    return c;
  endfunction

  function automatic logic [7:0] lane_byte(
    input logic [8*IN_BYTES-1:0] d,
    input logic [2:0]            l
  );
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (l == 3'(i)) b = d[i*8 +: 8];
    end
    return b;
  endfunction

  assign load = !mvld_q || m_ready;
  assign s_ready = ((state_q == DATA) && !bvld_q)
                || (state_q == DRAIN);
  assign acc = s_valid && s_ready;
  assign n_in = pop(s_keep);
  assign sum = {1'b0, cnt_q} + 17'(n_in);
  assign ovf = sum > MAXV;
  assign take = ovf ? 3'(MAXV - {1'b0, cnt_q}) : n_in;
  assign cur_byte = lane_byte(bdata_q, blane_q);
  assign cur_nib = bhi_q ? cur_byte[7:4] : cur_byte[3:0];

  // Next-state, buffer and output-register load logic
  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bdata_d  = bdata_q;
    bn_d     = bn_q;
    blane_d  = blane_q;
    bhi_d    = bhi_q;
    bvld_d   = bvld_q;
    blast_d  = blast_q;
    bdrain_d = bdrain_q;
    sym_d    = sym_q;
    mvld_d   = mvld_q;
    mlast_d  = mlast_q;
    err_d    = 1'b0;
    if (load) begin
      mvld_d  = 1'b0;
      mlast_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sop_type == 3'd7) begin
            err_d = 1'b1;
          end else begin
            type_d   = sop_type;
            sym_d    = oset(sop_type, 2'd0);
            mvld_d   = 1'b1;
            idx_d    = 2'd1;
            cnt_d    = 16'd0;
            bvld_d   = 1'b0;
            bdrain_d = 1'b0;
            state_d  = OSET;
          end
        end
      end
      OSET: begin
        if (load) begin
          sym_d  = oset(type_q, idx_q);
          mvld_d = 1'b1;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (type_q >= 3'd5) begin
              mlast_d = 1'b1;
              state_d = DONE;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (bvld_q && load) begin
          sym_d  = enc(cur_nib);
          mvld_d = 1'b1;
          if (bhi_q) begin
            bhi_d   = 1'b0;
            blane_d = blane_q + 3'd1;
            if (blane_q + 3'd1 == bn_q) begin
              bvld_d = 1'b0;
              if (blast_q)       state_d = EOP;
              else if (bdrain_q) state_d = DRAIN;
            end
          end else begin
            bhi_d = 1'b1;
          end
        end
        if (acc) begin
          if (n_in == 3'd0) begin
            err_d = 1'b1;
            if (s_last) state_d = EOP;
          end else begin
            if (ovf) err_d = 1'b1;
            cnt_d = ovf ? MAXV[15:0] : sum[15:0];
            if (take == 3'd0) begin
              state_d = s_last ? EOP : DRAIN;
            end else begin
              bvld_d   = 1'b1;
              bdata_d  = s_data;
              bn_d     = take;
              blane_d  = 3'd0;
              bhi_d    = 1'b0;
              blast_d  = s_last;
              bdrain_d = ovf && !s_last;
            end
          end
        end
      end
      DRAIN: begin
        if (acc && s_last) state_d = EOP;
      end
      EOP: begin
        if (load) begin
          sym_d   = K_EOP;
          mvld_d  = 1'b1;
          mlast_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (mvld_q && m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      type_q   <= 3'd0;
      idx_q    <= 2'd0;
      cnt_q    <= 16'd0;
      bdata_q  <= '0;
      bn_q     <= 3'd0;
      blane_q  <= 3'd0;
      bhi_q    <= 1'b0;
      bvld_q   <= 1'b0;
      blast_q  <= 1'b0;
      bdrain_q <= 1'b0;
      sym_q    <= 5'd0;
      mvld_q   <= 1'b0;
      mlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      bdata_q  <= bdata_d;
      bn_q     <= bn_d;
      blane_q  <= blane_d;
      bhi_q    <= bhi_d;
      bvld_q   <= bvld_d;
      blast_q  <= blast_d;
      bdrain_q <= bdrain_d;
      sym_q    <= sym_d;
      mvld_q   <= mvld_d;
      mlast_q  <= mlast_d;
      err_q    <= err_d;
    end
  end

  assign m_sym   = sym_q;
  assign m_valid = mvld_q;
  assign m_last  = mlast_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

endmodule

// File: tb/tb_pd_4b5b_tx_framer.sv
// Directed bench for pd_4b5b_tx_framer with a symbol scoreboard.
// Instance A: 1 byte/beat, 4-byte limit. Instance B: 2 bytes/beat.
module tb_pd_4b5b_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [2:0]  sop_type = 3'd0;
  logic [7:0]  sd_a = 8'h00;
  logic [0:0]  ka = 1'b0;
  logic [15:0] sd_b = 16'h0000;
  logic [1:0]  kb = 2'b00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready;

  logic       a_sr, a_mv, a_ml, a_busy, a_err;
  logic [4:0] a_ms;
  logic       b_sr, b_mv, b_ml, b_busy, b_err;
  logic [4:0] b_ms;

  pd_4b5b_tx_framer #(.IN_BYTES(1), .MAX_BYTES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .sop_type(sop_type), .s_data(sd_a), .s_keep(ka),
    .s_valid(s_valid), .s_last(s_last), .s_ready(a_sr),
    .m_sym(a_ms), .m_valid(a_mv), .m_ready(m_ready),
    .m_last(a_ml), .busy(a_busy), .err(a_err)
  );

  pd_4b5b_tx_framer #(.IN_BYTES(2), .MAX_BYTES(264)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .sop_type(sop_type), .s_data(sd_b), .s_keep(kb),
    .s_valid(s_valid), .s_last(s_last), .s_ready(b_sr),
    .m_sym(b_ms), .m_valid(b_mv), .m_ready(m_ready),
    .m_last(b_ml), .busy(b_busy), .err(b_err)
  );

  logic sel = 1'b0;
  logic bp = 1'b0;
  wire       mv   = sel ? b_mv : a_mv;
  wire       ml   = sel ? b_ml : a_ml;
  wire [4:0] ms   = sel ? b_ms : a_ms;
  wire       sr   = sel ? b_sr : a_sr;
  wire       bsy  = sel ? b_busy : a_busy;

  int pass_cnt = 0;
  int tot_cnt = 0;
  int nerr_a = 0;
  int nerr_b = 0;
  bit sr_seen = 1'b0;
  logic [5:0] expq[$];

  localparam logic [4:0] S1 = 5'b11000;
  localparam logic [4:0] S2 = 5'b10001;
  localparam logic [4:0] S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111;
  localparam logic [4:0] R2 = 5'b11001;
  localparam logic [4:0] EP = 5'b01101;
  logic [4:0] ENC [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101,
    5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111,
    5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tot_cnt++;
    assert (got === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, got, exp);
  endtask

  task automatic push(input logic [4:0] s,
                      input logic l = 1'b0);
    expq.push_back({l, s});
  endtask

  task automatic push_byte(input logic [7:0] b);
    push(ENC[b[3:0]]);
    push(ENC[b[7:4]]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pseudo-random backpressure when enabled
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop and hold-stability
  logic       hold = 1'b0;
  logic [4:0] hsym = 5'd0;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold", {mv, ms}, {1'b1, hsym});
      if (mv && m_ready) begin
        if (expq.size() == 0) begin
          tot_cnt++;
          $error("FAIL unexpected: observed %b expected none",
                 {ml, ms});
        end else begin
          chk("sym", {ml, ms}, expq.pop_front());
        end
      end
      hold = mv && !m_ready;
      hsym = ms;
      if (sr) sr_seen = 1'b1;
      if (a_err) nerr_a++;
      if (b_err) nerr_b++;
    end
  end

  task automatic do_start(input logic [2:0] t);
    sop_type = t;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input logic [15:0] d,
                      input logic [1:0] k,
                      input logic l);
    int n;
    sd_a = d[7:0];
    ka = k[0];
    sd_b = d;
    kb = k;
    s_last = l;
    s_valid = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sr) break;
    end
    if (n == 300) begin
      tot_cnt++;
      $error("FAIL s_ready_timeout: observed 0 expected 1");
    end
    step();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!bsy) break;
    end
    chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_left"}, expq.size(), 0);
  endtask

  task automatic frame1(input logic [7:0] b,
                        input string tag);
    int e0;
    e0 = nerr_a;
    push(S1); push(S1); push(S1); push(S2);
    push_byte(b);
    push(EP, 1'b1);
    do_start(3'd0);
    @(negedge clk);
    chk({tag, "_busy_hi"}, a_busy, 1);
    send({8'h00, b}, 2'b01, 1'b1);
    wait_idle(tag);
    chk({tag, "_err"}, nerr_a - e0, 0);
  endtask

  int e0;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    @(negedge clk);
    chk("reset_a", {a_sr, a_mv, a_ms, a_ml, a_busy, a_err}, 0);
    chk("reset_b", {b_sr, b_mv, b_ms, b_ml, b_busy, b_err}, 0);
    rst = 1'b0;
    step();

    // SOP, one byte
    frame1(8'hA5, "t1");

    // Hard Reset ordered set, then reserved type
    sr_seen = 1'b0;
    push(R1); push(R1); push(R1); push(R2, 1'b1);
    do_start(3'd5);
    wait_idle("t2");
    chk("t2_sready", sr_seen, 0);
    e0 = nerr_a;
    do_start(3'd7);
    repeat (3) @(negedge clk);
    chk("t2_rsv_err", nerr_a - e0, 1);
    chk("t2_rsv_busy", a_busy, 0);

    // Two-byte beats with partial last beat
    sel = 1'b1;
    e0 = nerr_b;
    push(S1); push(S1); push(S3); push(S3);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push(EP, 1'b1);
    do_start(3'd1);
    send(16'h3412, 2'b11, 1'b0);
    send(16'h0056, 2'b01, 1'b1);
    wait_idle("t3");
    chk("t3_err", nerr_b - e0, 0);
    sel = 1'b0;

    // Backpressure
    bp = 1'b1;
    frame1(8'hA5, "t4");
    frame1(8'h7E, "t4b");
    bp = 1'b0;
    step();

    // Length overflow at 4 bytes
    e0 = nerr_a;
    push(S1); push(S1); push(S1); push(S2);
    for (int i = 0; i < 4; i++) push_byte(8'(i));
    push(EP, 1'b1);
    do_start(3'd0);
    for (int i = 0; i < 6; i++) begin
      send(16'(i), 2'b01, i == 5);
    end
    wait_idle("t5");
    chk("t5_err", nerr_a - e0, 1);

    // Reset mid-DATA aborts without EOP
    push(S1); push(S1); push(S1); push(S2);
    push_byte(8'h11);
    do_start(3'd0);
    send(16'h0011, 2'b01, 1'b0);
    repeat (4) step();
    chk("t6_sent", expq.size(), 0);
    chk("t6_busy", a_busy, 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst", {a_sr, a_mv, a_ms, a_ml, a_busy, a_err}, 0);
    rst = 1'b0;
    repeat (5) step();
    frame1(8'h3C, "t6b");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
